// File: rtl/alu_seq_if.sv
// Operand, control and flag bundle between the register-file side and alu_seq.
// Clock, reset and the tristate bus pin stay plain ports on the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bWr;
    logic             i_start;
    logic [1:0]       i_aluOp;
    logic             i_sub;
    logic             i_useCarry;
    logic             i_shiftLeft;
    logic             i_shiftArith;
    logic             i_rotate;
    logic             o_busy;
    logic             o_done;
    logic             o_negative;
    logic             o_zero;
    logic             o_carry;
    logic             o_overflow;

    modport master (
        output i_a, i_b, i_bWr, i_start, i_aluOp, i_sub, i_useCarry,
               i_shiftLeft, i_shiftArith, i_rotate,
        input  o_busy, o_done, o_negative, o_zero, o_carry, o_overflow
    );

    modport slave (
        input  i_a, i_b, i_bWr, i_start, i_aluOp, i_sub, i_useCarry,
               i_shiftLeft, i_shiftArith, i_rotate,
        output o_busy, o_done, o_negative, o_zero, o_carry, o_overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: registered add/sub/and/xor with N/Z/C/V flags and an
// iterative one-bit-per-cycle shifter; result drives the shared bus via tristate.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic             i_oe,
    output wire  [WIDTH-1:0] o_y,
    alu_seq_if.slave         bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [WIDTH-1:0] W_V     = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d, b_q, b_d, work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, done_q, done_d;
    logic             left_q, left_d, arith_q, arith_d, rot_q, rot_d;

    // One shift step on the working register, plus the bit that falls out
    logic [WIDTH-1:0] sh;
    logic             sh_out, fill;
    always_comb begin
        if (left_q) begin
            sh_out = work_q[WIDTH-1];
            fill   = rot_q ? sh_out : 1'b0;
            sh     = {work_q[WIDTH-2:0], fill};
        end else begin
            sh_out = work_q[0];
            fill   = rot_q ? sh_out : (arith_q ? work_q[WIDTH-1] : 1'b0);
            sh     = {fill, work_q[WIDTH-1:1]};
        end
    end

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic [CNT_W-1:0] n_shift;
    always_comb begin
        cin = bus.i_useCarry ? c_q : bus.i_sub;
        bx  = bus.i_sub ? ~b_q : b_q;
        sum = {1'b0, bus.i_a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
        if (bus.i_rotate)
            n_shift = {1'b0, b_q[CNT_W-2:0]};
        else
            n_shift = (b_q >= W_V) ? CNT_MAX : b_q[CNT_W-1:0];
    end

    logic             wr;
    logic [WIDTH-1:0] res;
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        b_d     = bus.i_bWr ? bus.i_b : b_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        left_d  = left_q;
        arith_d = arith_q;
        rot_d   = rot_q;
        done_d  = 1'b0;
        wr      = 1'b0;
        res     = y_q;
        case (state_q)
            IDLE: if (bus.i_start) begin
                case (bus.i_aluOp)
                    2'b00: begin
                        wr  = 1'b1;
                        res = sum[WIDTH-1:0];
                        c_d = sum[WIDTH];
                        v_d = (bus.i_a[WIDTH-1] == bx[WIDTH-1]) &&
                              (sum[WIDTH-1] != bus.i_a[WIDTH-1]);
                    end
                    2'b01: begin
                        wr = 1'b1; res = bus.i_a & b_q; c_d = 1'b0; v_d = 1'b0;
                    end
                    2'b10: begin
                        wr = 1'b1; res = bus.i_a ^ b_q; c_d = 1'b0; v_d = 1'b0;
                    end
                    default: begin
                        if (n_shift == '0) begin
                            wr = 1'b1; res = bus.i_a; c_d = 1'b0; v_d = 1'b0;
                        end else begin
                            work_d  = bus.i_a;
                            cnt_d   = n_shift;
                            left_d  = bus.i_shiftLeft;
                            arith_d = bus.i_shiftArith & ~bus.i_rotate;
                            rot_d   = bus.i_rotate;
                            state_d = SHIFT;
                        end
                    end
                endcase
            end
            SHIFT: begin
                work_d = sh;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    wr      = 1'b1;
                    res     = sh;
                    c_d     = sh_out;
                    v_d     = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr) begin
            y_d    = res;
            n_d    = res[WIDTH-1];
            z_d    = (res == '0);
            done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q <= IDLE;
            y_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            b_q     <= b_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            done_q  <= done_d;
            left_q  <= left_d;
            arith_q <= arith_d;
            rot_q   <= rot_d;
        end
    end

    assign o_y            = i_oe ? y_q : {WIDTH{1'bz}};
    assign bus.o_busy     = (state_q == SHIFT);
    assign bus.o_done     = done_q;
    assign bus.o_negative = n_q;
    assign bus.o_zero     = z_q;
    assign bus.o_carry    = c_q;
    assign bus.o_overflow = v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus queues hand-computed results, a
// monitor pops and checks them on every o_done pulse.
module tb_alu_seq;
    logic       i_clk = 1'b0;
    logic       i_nReset = 1'b0;
    logic       i_oe = 1'b1;
    wire  [7:0] o_y;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .i_clk    (i_clk),
        .i_nReset (i_nReset),
        .i_oe     (i_oe),
        .o_y      (o_y),
        .bus      (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0] y;
        logic       oe;
        logic       n, z, c, v;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] y_prev = 8'h00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every o_done cycle consumes exactly one expected entry
    always @(negedge i_clk) begin
        if (bus.o_done === 1'b1) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got done=1 expected no pending result");
            end else begin
                e = sb.pop_front();
                if (e.oe) chk("result", o_y, e.y);
                else begin
                    total++;
                    if (o_y === e.y) begin
                        bad++;
                        $display("FAIL bus_released: got %h expected not driven", o_y);
                    end
                end
                chk("flags_nzcv", {4'h0, bus.o_negative, bus.o_zero, bus.o_carry, bus.o_overflow},
                    {4'h0, e.n, e.z, e.c, e.v});
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic sub, input logic uc, input logic left, input logic arith,
                         input logic rot, input logic oe, input logic [7:0] y,
                         input logic [3:0] nzcv, input int busy_exp, input bit disturb);
        int cnt;
        @(posedge i_clk); #1;
        bus.i_b = b; bus.i_bWr = 1'b1;
        @(posedge i_clk); #1;
        bus.i_bWr = 1'b0; bus.i_a = a; bus.i_aluOp = op; bus.i_sub = sub;
        bus.i_useCarry = uc; bus.i_shiftLeft = left; bus.i_shiftArith = arith;
        bus.i_rotate = rot; i_oe = oe; bus.i_start = 1'b1;
        sb.push_back({y, oe, nzcv});
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        cnt = 0;
        @(negedge i_clk);
        while (bus.o_busy === 1'b1 && cnt < 40) begin
            if (oe) chk("y_held_busy", o_y, y_prev);
            if (disturb && cnt == 2) begin
                bus.i_start = 1'b1; bus.i_aluOp = 2'b00; bus.i_b = 8'h01; bus.i_bWr = 1'b1;
            end
            if (disturb && cnt == 3) begin
                bus.i_start = 1'b0; bus.i_bWr = 1'b0;
            end
            cnt++;
            @(negedge i_clk);
        end
        chk("busy_cycles", 8'(cnt), 8'(busy_exp));
        y_prev = y;
        @(negedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        int cnt;
        bus.i_a = '0; bus.i_b = '0; bus.i_bWr = 0; bus.i_start = 0; bus.i_aluOp = 0;
        bus.i_sub = 0; bus.i_useCarry = 0; bus.i_shiftLeft = 0; bus.i_shiftArith = 0;
        bus.i_rotate = 0;
        #12;
        chk("reset_y", o_y, 8'h00);
        chk("reset_ctl", {6'h0, bus.o_busy, bus.o_done}, 8'h00);
        i_nReset = 1'b1;

        //     a      b      op    sb uc l  ar r  oe  y      NZCV     busy
        issue(8'h14, 8'h16, 2'b00, 0, 0, 0, 0, 0, 1, 8'h2A, 4'b0000, 0, 0);
        issue(8'h14, 8'h16, 2'b00, 0, 0, 0, 0, 0, 0, 8'h2A, 4'b0000, 0, 0);
        issue(8'h7F, 8'h01, 2'b00, 0, 0, 0, 0, 0, 1, 8'h80, 4'b1001, 0, 0);
        issue(8'hC8, 8'h38, 2'b00, 0, 0, 0, 0, 0, 1, 8'h00, 4'b0110, 0, 0);
        issue(8'h00, 8'h00, 2'b00, 0, 1, 0, 0, 0, 1, 8'h01, 4'b0000, 0, 0);
        issue(8'h2A, 8'h0F, 2'b00, 1, 0, 0, 0, 0, 1, 8'h1B, 4'b0010, 0, 0);
        issue(8'h0F, 8'h2A, 2'b00, 1, 0, 0, 0, 0, 1, 8'hE5, 4'b1000, 0, 0);
        issue(8'h80, 8'h01, 2'b00, 1, 0, 0, 0, 0, 1, 8'h7F, 4'b0011, 0, 0);
        issue(8'hF0, 8'h3C, 2'b01, 0, 0, 0, 0, 0, 1, 8'h30, 4'b0000, 0, 0);
        issue(8'hFF, 8'hFF, 2'b10, 0, 0, 0, 0, 0, 1, 8'h00, 4'b0100, 0, 0);
        issue(8'h2A, 8'h03, 2'b11, 0, 0, 1, 0, 0, 1, 8'h50, 4'b0010, 3, 0);
        issue(8'h95, 8'h02, 2'b11, 0, 0, 0, 1, 0, 1, 8'hE5, 4'b1000, 2, 0);
        issue(8'h81, 8'h09, 2'b11, 0, 0, 1, 0, 1, 1, 8'h03, 4'b0010, 1, 0);
        issue(8'hA5, 8'h00, 2'b11, 0, 0, 0, 0, 0, 1, 8'hA5, 4'b1000, 0, 0);
        issue(8'h2A, 8'hC8, 2'b11, 0, 0, 1, 0, 0, 1, 8'h00, 4'b0100, 8, 1);
        issue(8'h80, 8'hFF, 2'b11, 0, 0, 0, 1, 0, 1, 8'hFF, 4'b1010, 8, 0);

        // Shift by 5 interrupted by reset after two busy cycles
        @(posedge i_clk); #1;
        bus.i_b = 8'h05; bus.i_bWr = 1'b1;
        @(posedge i_clk); #1;
        bus.i_bWr = 1'b0; bus.i_a = 8'h2A; bus.i_aluOp = 2'b11; bus.i_shiftLeft = 1'b1;
        bus.i_shiftArith = 1'b0; bus.i_rotate = 1'b0; i_oe = 1'b1; bus.i_start = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        cnt = 0;
        repeat (2) begin
            @(negedge i_clk);
            if (bus.o_busy === 1'b1) cnt++;
        end
        chk("busy_before_reset", 8'(cnt), 8'd2);
        i_nReset = 1'b0;
        #1;
        chk("midshift_reset_y", o_y, 8'h00);
        chk("midshift_reset_st", {2'b0, bus.o_busy, bus.o_done, bus.o_negative, bus.o_zero,
                                  bus.o_carry, bus.o_overflow}, 8'h00);
        @(posedge i_clk); #1;
        i_nReset = 1'b1;
        y_prev = 8'h00;
        issue(8'h01, 8'h01, 2'b00, 0, 0, 0, 0, 0, 1, 8'h02, 4'b0000, 0, 0);

        repeat (4) @(negedge i_clk);
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the 8-bit CPU ALU.
- Adds a registered result and flag set, carry/overflow flags, and add/sub with carry-in for multi-word arithmetic.
- Adds an iterative shifter (logical, arithmetic, rotate) with a start/busy/done handshake.
- Sits between the register file and the shared data bus; drives the bus through a tristate output.

Parameters:
WIDTH, 8, datapath width in bits; must be a power of 2, minimum 4.
CNT_W, $clog2(WIDTH)+1, shift-counter width; derived, not overridden.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_nReset  input  1  asynchronous active-low reset
i_a  input  WIDTH  operand A, sampled at the start edge
i_b  input  WIDTH  operand B bus value
i_bWr  input  1  load i_b into internal B register on rising edge
i_start  input  1  request operation; accepted when o_busy=0
i_aluOp  input  2  00 add/sub, 01 and, 10 xor, 11 shift
i_sub  input  1  aluOp 00: subtract
i_useCarry  input  1  aluOp 00: carry-in = o_carry instead of i_sub
i_shiftLeft  input  1  aluOp 11: direction, 1 = left
i_shiftArith  input  1  aluOp 11, right only: sign-fill
i_rotate  input  1  aluOp 11: rotate; overrides i_shiftArith
i_oe  input  1  drive o_y
o_y  output  WIDTH  result register when i_oe=1, else all 'z'
o_busy  output  1  multi-cycle shift in progress
o_done  output  1  one-cycle pulse: new result/flags valid
o_negative, o_zero, o_carry, o_overflow  output  1 each  registered flags

Behaviour:
- Reset (async, any state, including mid-shift):
  - FSM -> IDLE.
  - Result, B register, counter, all flags, o_busy and o_done -> 0.
  - o_y still obeys i_oe.
- B register: loaded from i_b on every edge where i_bWr=1, including while busy. The running shift is unaffected because the count and operand are latched at start.
- Operations use A from i_a at the start edge and B from the B register value before that edge.
- o_y is combinational on i_oe. While busy it shows the previous result; the result register changes only on completion.
- FSM states: IDLE, SHIFT.
  - Start is accepted at edge E0 when i_start=1 and the FSM is in IDLE.
  - i_start while busy is ignored; no queuing.
- Single-cycle ops (aluOp 00/01/10, or shift count 0):
  - Result and flags are written at E0.
  - o_done=1 from E0 to E1.
  - o_busy never asserts.
- Add/sub:
  - cin = i_useCarry ? o_carry : i_sub.
  - y = a + (i_sub ? ~b : b) + cin, computed at WIDTH+1 bits.
  - carry = bit WIDTH (for sub: 1 = no borrow).
  - overflow = signed overflow of the addend pair.
- And/xor: carry and overflow are cleared.
- Shift count:
  - Rotate: n = b mod WIDTH.
  - Otherwise: n = min(b, WIDTH).
- Shift with n ≥ 1:
  - At E0: work <= a, cnt <= n, go to SHIFT, o_busy=1.
  - Each SHIFT edge: shift work by 1 bit and decrement cnt.
  - At edge E_n: result <= shifted work, flags written, return to IDLE, o_busy=0.
  - o_busy is high from E0 to E_n; o_done is high from E_n to E_n+1.
  - Shift-in fill: logical = 0; arithmetic right = original MSB; rotate = the bit shifted out.
  - carry = last bit shifted out (rotate: last wrapped bit).
  - overflow = 0.
  - Arithmetic left behaves as logical left.
  - A count clamped to WIDTH clears the result for logical shifts and sign-fills it for arithmetic right.
- Shift with n = 0: result = a, carry = 0, single-cycle timing.
- Negative = result MSB; zero = (result == 0). Both are written together with the result.

Test Plan:
1. Add 0x14+0x16 with o_busy=0 throughout -> o_y=0x2A one edge after start, o_done one-cycle pulse, flags N/Z/C/V all 0. Repeat with i_oe=0 -> o_y='z'.
2. Add with flag checks:
   - 0x7F+0x01 -> 0x80, N=1, V=1, C=0.
   - 0xC8+0x38 -> 0x00, Z=1, C=1.
   - Then i_useCarry=1: 0x00+0x00 -> 0x01.
3. Subtract:
   - 0x2A-0x0F -> 0x1B, C=1.
   - 0x0F-0x2A -> 0xE5, N=1, C=0.
   - 0x80-0x01 -> 0x7F, V=1.
4. Shifts:
   - Left 0x2A by 3 -> o_busy exactly 3 cycles, o_y old value until done, then 0x50, C=1.
   - Arithmetic right 0x95 by 2 -> 0xE5, C=0.
   - Rotate left 0x81 by 9 -> n=1, 0x03, C=1.
5. Left 0x2A by 200 -> count clamped to 8, busy 8 cycles, result 0x00, Z=1, C=0. Second i_start and an i_bWr during busy -> ignored / no effect on result.
6. Start a shift by 5 and assert i_nReset low after 2 cycles -> o_busy, o_done, result and flags immediately 0. After release, add 0x01+0x01 -> 0x02 normally.
